// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the DataMemory arbiter.
package mem_arb_pkg;

   // Arbiter FSM encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // DataMemory read latency in cycles (issue to data)
   localparam int unsigned MEM_READ_LAT = 1;

   // Width of a requester index (supports up to 4 requesters)
   localparam int unsigned OWN_W = 2;

   // DataMemory port geometry
   localparam int unsigned WE_W   = 4;
   localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: first set request at or after rr_ptr, wrapping.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWN_W-1:0]   rr_ptr,
   output logic [OWN_W-1:0]   winner,
   output logic               found
);

   logic             hi_found;
   logic [OWN_W-1:0] hi_win;
   logic             lo_found;
   logic [OWN_W-1:0] lo_win;

   // Lowest set index >= rr_ptr wins; otherwise lowest set index below rr_ptr
   always_comb begin
      hi_found = 1'b0;
      hi_win   = '0;
      lo_found = 1'b0;
      lo_win   = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (req[j]) begin
            if (OWN_W'(j) >= rr_ptr) begin
               if (!hi_found) begin
                  hi_found = 1'b1;
                  hi_win   = OWN_W'(j);
               end
            end else if (!lo_found) begin
               lo_found = 1'b1;
               lo_win   = OWN_W'(j);
            end
         end
      end
      found  = hi_found | lo_found;
      winner = hi_found ? hi_win : lo_win;
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one DataMemory port between NUM_REQ requesters,
// with req/gnt/rvalid handshake and lock-driven bursts capped at MAX_LOCK grants.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          lock,
   input  logic [WE_W*NUM_REQ-1:0]     req_we,
   input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
   input  logic [DATA_W*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REQ-1:0]          rvalid,
   output logic [DATA_W-1:0]           rdata,
   output logic                        mem_en,
   output logic [WE_W-1:0]             mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [OWN_W-1:0]            owner
);

   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   state_t             state;
   state_t             state_nxt;
   logic [OWN_W-1:0]   owner_nxt;
   logic [OWN_W-1:0]   rr_ptr;
   logic [OWN_W-1:0]   rr_nxt;
   logic [OWN_W-1:0]   rr_inc;
   logic [CNT_W-1:0]   lock_cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic               lock_q;
   logic               lock_q_nxt;
   logic               cnt_room;

   logic               sel_req;
   logic               sel_lock;
   logic [WE_W-1:0]    sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic [NUM_REQ-1:0] owner_oh;
   logic               is_read;

   logic [OWN_W-1:0]   winner;
   logic               found;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .found  (found)
   );

   // Mux the current owner's request fields onto the shared path
   always_comb begin
      sel_req   = 1'b0;
      sel_lock  = 1'b0;
      sel_we    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      owner_oh  = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (owner == OWN_W'(j)) begin
            owner_oh[j] = 1'b1;
            sel_req     = req[j];
            sel_lock    = lock[j];
            sel_we      = req_we[j*WE_W +: WE_W];
            sel_addr    = req_addr[j*ADDR_W +: ADDR_W];
            sel_wdata   = req_wdata[j*DATA_W +: DATA_W];
         end
      end
   end

   assign is_read  = (sel_we == '0);
   assign cnt_room = (lock_cnt < CNT_W'(MAX_LOCK - 1));
   assign rr_inc   = (owner == OWN_W'(NUM_REQ - 1)) ? '0 : owner + OWN_W'(1);

   // State and arbitration bookkeeping registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= '0;
         rr_ptr   <= '0;
         lock_cnt <= '0;
         lock_q   <= 1'b0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_nxt;
         lock_cnt <= cnt_nxt;
         lock_q   <= lock_q_nxt;
      end
   end

   // Next-state and bookkeeping updates
   always_comb begin
      state_nxt  = state;
      owner_nxt  = owner;
      rr_nxt     = rr_ptr;
      cnt_nxt    = lock_cnt;
      lock_q_nxt = lock_q;
      case (state)
         IDLE: begin
            if (found) begin
               owner_nxt = winner;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!sel_req) begin
               // Withdrawal: release without advancing the pointer
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else if (is_read) begin
               lock_q_nxt = sel_lock;
               state_nxt  = RESP;
            end else if (sel_lock && cnt_room) begin
               cnt_nxt = lock_cnt + CNT_W'(1);
            end else begin
               cnt_nxt   = '0;
               rr_nxt    = rr_inc;
               state_nxt = IDLE;
            end
         end
         RESP: begin
            if (lock_q && cnt_room) begin
               cnt_nxt   = lock_cnt + CNT_W'(1);
               state_nxt = ISSUE;
            end else begin
               cnt_nxt   = '0;
               rr_nxt    = rr_inc;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Handshake and memory port outputs decoded from state
   always_comb begin
      gnt       = '0;
      rvalid    = '0;
      rdata     = '0;
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         ISSUE: begin
            mem_en    = sel_req;
            mem_we    = sel_req ? sel_we : '0;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
            gnt       = owner_oh & {NUM_REQ{sel_req}};
         end
         RESP: begin
            rvalid = owner_oh;
            rdata  = mem_rdata;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a 1-cycle synchronous memory model.
module tb_data_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned NUM_REQ  = 2;
   localparam int unsigned ADDR_W   = 11;
   localparam int unsigned MAX_LOCK = 4;

   logic                      clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        lock;
   logic [4*NUM_REQ-1:0]      req_we;
   logic [ADDR_W*NUM_REQ-1:0] req_addr;
   logic [32*NUM_REQ-1:0]     req_wdata;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [31:0]               rdata;
   logic                      mem_en;
   logic [3:0]                mem_we;
   logic [ADDR_W-1:0]         mem_addr;
   logic [31:0]               mem_wdata;
   logic [31:0]               mem_rdata;
   logic [1:0]                owner;

   logic [31:0] mem [0:2047];

   int total = 0;
   int bad   = 0;

   logic [1:0] cont_exp  [8];
   logic [1:0] burst_exp [12];

   data_mem_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ADDR_W   (ADDR_W),
      .MAX_LOCK (MAX_LOCK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .lock      (lock),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .owner     (owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DataMemory model: byte-enabled write, read-first 1-cycle read
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         mem_rdata <= mem[mem_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic idx, input logic r, input logic l, input logic [3:0] we,
                        input logic [10:0] a, input logic [31:0] d);
      if (idx) begin
         req[1] = r; lock[1] = l; req_we[7:4] = we; req_addr[21:11] = a; req_wdata[63:32] = d;
      end else begin
         req[0] = r; lock[0] = l; req_we[3:0] = we; req_addr[10:0] = a; req_wdata[31:0] = d;
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   // Unlocked single write from IDLE with no competing request
   task automatic do_write(input logic idx, input logic [10:0] a, input logic [3:0] we,
                           input logic [31:0] d, input string tag);
      drive(idx, 1'b1, 1'b0, we, a, d);
      #1;
      step();
      check_eq({tag, "_gnt"}, 32'(gnt), idx ? 32'd2 : 32'd1);
      step();
      drive(idx, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;
   endtask

   // Unlocked single read from IDLE; gnt-to-rvalid latency is measured with a bound
   task automatic do_read(input logic idx, input logic [10:0] a, input logic [31:0] exp_d,
                          input string tag);
      int lat;
      drive(idx, 1'b1, 1'b0, 4'h0, a, 32'h0);
      #1;
      step();
      check_eq({tag, "_gnt"}, 32'(gnt), idx ? 32'd2 : 32'd1);
      step();
      drive(idx, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;
      lat = 1;
      while (rvalid == '0 && lat < 4) begin
         step();
         lat++;
      end
      check_eq({tag, "_lat"}, 32'(lat), 32'(MEM_READ_LAT));
      check_eq({tag, "_rvalid"}, 32'(rvalid), idx ? 32'd2 : 32'd1);
      check_eq({tag, "_rdata"}, rdata, exp_d);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n1;
      logic r0done;

      cont_exp  = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
      burst_exp = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0};

      reset     = 1'b1;
      req       = '0;
      lock      = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      step();
      step();

      // Reset state
      check_eq("rst_gnt",    32'(gnt),    32'd0);
      check_eq("rst_rvalid", 32'(rvalid), 32'd0);
      check_eq("rst_mem_en", 32'(mem_en), 32'd0);
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      check_eq("rst_rdata",  rdata,       32'd0);
      check_eq("rst_addr",   32'(mem_addr), 32'd0);
      check_eq("rst_wdata",  mem_wdata,   32'd0);
      check_eq("rst_owner",  32'(owner),  32'd0);
      reset = 1'b0;
      #1;

      // Single read of 0x010 holding DEADBEEF, cycle by cycle
      do_write(1'b0, 11'h010, 4'hF, 32'hDEADBEEF, "pre010");
      drive(1'b0, 1'b1, 1'b0, 4'h0, 11'h010, 32'h0);
      #1;
      check_eq("rd_c0_gnt", 32'(gnt), 32'd0);
      check_eq("rd_c0_en",  32'(mem_en), 32'd0);
      step();
      check_eq("rd_c1_gnt",  32'(gnt), 32'd1);
      check_eq("rd_c1_en",   32'(mem_en), 32'd1);
      check_eq("rd_c1_addr", 32'(mem_addr), 32'h010);
      check_eq("rd_c1_we",   32'(mem_we), 32'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;
      check_eq("rd_c2_rvalid", 32'(rvalid), 32'd1);
      check_eq("rd_c2_rdata",  rdata, 32'hDEADBEEF);
      check_eq("rd_c2_en",     32'(mem_en), 32'd0);
      step();
      check_eq("rd_c3_rvalid", 32'(rvalid), 32'd0);
      check_eq("rd_c3_rdata",  rdata, 32'd0);

      // Contention: two unlocked writers alternate 0,1,0,1
      apply_reset();
      drive(1'b0, 1'b1, 1'b0, 4'hF, 11'h020, 32'h11111111);
      drive(1'b1, 1'b1, 1'b0, 4'hF, 11'h030, 32'h22222222);
      #1;
      for (int c = 0; c < 8; c++) begin
         check_eq($sformatf("cont_c%0d", c), 32'(gnt), 32'(cont_exp[c]));
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;
      check_eq("cont_mem020", mem[11'h020], 32'h11111111);
      check_eq("cont_mem030", mem[11'h030], 32'h22222222);

      // Locked burst from req1 capped at MAX_LOCK, req0 slips in before the rest
      n1 = 0;
      r0done = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (n1 < 6) drive(1'b1, 1'b1, 1'b1, 4'hF, 11'h040 + 11'(n1), 32'hA0 + 32'(n1));
         else        drive(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
         if (c >= 1 && !r0done) drive(1'b0, 1'b1, 1'b0, 4'hF, 11'h050, 32'h55555555);
         else                   drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
         #1;
         check_eq($sformatf("burst_c%0d", c), 32'(gnt), 32'(burst_exp[c]));
         if (gnt[1]) n1++;
         if (gnt[0]) r0done = 1'b1;
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;
      check_eq("burst_n1",     32'(n1), 32'd6);
      check_eq("burst_mem040", mem[11'h040], 32'hA0);
      check_eq("burst_mem045", mem[11'h045], 32'hA5);
      check_eq("burst_mem050", mem[11'h050], 32'h55555555);

      // Withdraw in ISSUE: no grant, pointer unchanged
      apply_reset();
      drive(1'b0, 1'b1, 1'b0, 4'h0, 11'h010, 32'h0);
      #1;
      check_eq("wd_c0_gnt", 32'(gnt), 32'd0);
      step();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;
      check_eq("wd_c1_gnt",   32'(gnt), 32'd0);
      check_eq("wd_c1_en",    32'(mem_en), 32'd0);
      check_eq("wd_c1_owner", 32'(owner), 32'd0);
      step();
      check_eq("wd_c2_en", 32'(mem_en), 32'd0);
      drive(1'b0, 1'b1, 1'b0, 4'hF, 11'h060, 32'h66666666);
      drive(1'b1, 1'b1, 1'b0, 4'hF, 11'h061, 32'h77777777);
      #1;
      step();
      check_eq("wd_c3_gnt", 32'(gnt), 32'd1);
      step();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;
      step();
      check_eq("wd_c5_gnt", 32'(gnt), 32'd2);
      step();
      drive(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;

      // Reset during RESP aborts the read
      drive(1'b1, 1'b1, 1'b0, 4'h0, 11'h030, 32'h0);
      #1;
      step();
      check_eq("mr_c1_gnt",   32'(gnt), 32'd2);
      check_eq("mr_c1_owner", 32'(owner), 32'd1);
      step();
      drive(1'b1, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      reset = 1'b1;
      #1;
      check_eq("mr_rvalid", 32'(rvalid), 32'd0);
      check_eq("mr_en",     32'(mem_en), 32'd0);
      check_eq("mr_owner",  32'(owner), 32'd0);
      check_eq("mr_rdata",  rdata, 32'd0);
      step();
      reset = 1'b0;
      #1;
      do_read(1'b1, 11'h010, 32'hDEADBEEF, "mr_post");

      // Single-byte write touches only byte 2
      do_write(1'b0, 11'h005, 4'hF, 32'h12345678, "pre005");
      drive(1'b0, 1'b1, 1'b0, 4'b0100, 11'h005, 32'h00AB0000);
      #1;
      check_eq("bw_c0_we", 32'(mem_we), 32'd0);
      step();
      check_eq("bw_c1_we",   32'(mem_we), 32'h4);
      check_eq("bw_c1_en",   32'(mem_en), 32'd1);
      check_eq("bw_c1_addr", 32'(mem_addr), 32'h005);
      step();
      drive(1'b0, 1'b0, 1'b0, 4'h0, 11'h0, 32'h0);
      #1;
      check_eq("bw_c2_we", 32'(mem_we), 32'd0);
      do_read(1'b0, 11'h005, 32'h12AB5678, "bw_rb");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
